// File: rtl/fsm_run_sequencer.sv
// fsm_run_sequencer: queues run requests and issues one o_isRun pulse per job, waiting for done plus a gap between jobs.
// Optional WAIT-state watchdog enabled by defining FSM_SEQ_TIMEOUT_EN.
module fsm_run_sequencer #(
  parameter int PEND_W         = 4,
  parameter int CNT_W          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_done,
  output logic              o_isRun,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic [CNT_W-1:0]  o_done_count,
  output logic              o_done_pulse,
  output logic              o_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  if (PEND_W < 1 || CNT_W < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fsm_run_sequencer: illegal parameter set");
  end
  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              dp_q, dp_d;
  logic              accept, issue, done_ok, expire, to_gap;
`ifdef FSM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          tmo_q, tmo_d;
  // a done on the expiry edge wins over the watchdog
  always_comb begin
    expire = state_q == WAIT && !i_done && wcnt_q == TW'(TIMEOUT_CYCLES - 1);
    wcnt_d = state_q == WAIT ? wcnt_q + 1'b1 : '0;
    tmo_d  = tmo_q | expire;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_d;
    end
  end
  assign o_timeout = tmo_q;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      dp_q    <= dp_d;
    end
  end
  always_comb begin
    accept  = i_req_valid & o_req_ready;
    issue   = state_q == IDLE && pend_q != '0;
    done_ok = state_q == WAIT && i_done;
    to_gap  = done_ok | expire;
    pend_d  = pend_q + PEND_W'(accept) - PEND_W'(issue);
    cnt_d   = cnt_q + CNT_W'(done_ok);
    dp_d    = done_ok;
    gap_d   = to_gap ? GW'(GAP_CYCLES) : state_q == GAP ? gap_q - 1'b1 : gap_q;
    state_d = state_q == IDLE  ? (issue ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (to_gap ? (GAP_CYCLES == 0 ? IDLE : GAP) : WAIT) :
              (gap_q == GW'(1) ? IDLE : GAP);
  end
  always_comb begin
    o_isRun      = state_q == ISSUE;
    o_busy       = state_q != IDLE || pend_q != '0;
    o_req_ready  = pend_q != PEND_MAX;
    o_pending    = pend_q;
    o_done_count = cnt_q;
    o_done_pulse = dp_q;
  end
endmodule

// File: tb/tb_fsm_run_sequencer.sv
// tb_fsm_run_sequencer: directed vector table plus hand sequences for bursts, back-pressure and hung jobs.
module tb_fsm_run_sequencer;
  logic       clk = 1'b0, rst = 1'b0, v = 1'b0, d = 1'b0;
  logic       rdy, run, busy, dp, to;
  logic [3:0] pend;
  logic [7:0] cnt;
  int         errors = 0, checks = 0;
  fsm_run_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(v), .o_req_ready(rdy), .i_done(d),
    .o_isRun(run), .o_busy(busy), .o_pending(pend), .o_done_count(cnt),
    .o_done_pulse(dp), .o_timeout(to)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, v, d;
    logic run, rdy, busy, dp;
    logic [3:0] pend;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[23];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; v = 1'b0; d = 1'b0;
    step();
    rst = 1'b0;
  endtask
  initial begin
    int since, last, pulses, peak, bad, dps, n, tos, runs;
    vecs[0]  = '{1,0,0, 0,1,0,0, 0,0};
    vecs[1]  = '{0,1,0, 0,1,1,0, 1,0};
    vecs[2]  = '{0,0,0, 1,1,1,0, 0,0};
    vecs[3]  = '{0,0,0, 0,1,1,0, 0,0};
    vecs[4]  = '{0,0,0, 0,1,1,0, 0,0};
    vecs[5]  = '{0,0,0, 0,1,1,0, 0,0};
    vecs[6]  = '{0,0,1, 0,1,1,1, 0,1};
    vecs[7]  = '{0,0,0, 0,1,1,0, 0,1};
    vecs[8]  = '{0,0,0, 0,1,0,0, 0,1};
    vecs[9]  = '{0,0,1, 0,1,0,0, 0,1};
    vecs[10] = '{0,1,0, 0,1,1,0, 1,1};
    vecs[11] = '{0,0,1, 1,1,1,0, 0,1};
    vecs[12] = '{0,0,1, 0,1,1,0, 0,1};
    vecs[13] = '{0,0,1, 0,1,1,1, 0,2};
    vecs[14] = '{0,0,1, 0,1,1,0, 0,2};
    vecs[15] = '{0,0,1, 0,1,0,0, 0,2};
    vecs[16] = '{0,0,0, 0,1,0,0, 0,2};
    vecs[17] = '{0,1,0, 0,1,1,0, 1,2};
    vecs[18] = '{0,1,0, 1,1,1,0, 1,2};
    vecs[19] = '{0,1,0, 0,1,1,0, 2,2};
    vecs[20] = '{0,1,0, 0,1,1,0, 3,2};
    vecs[21] = '{1,0,0, 0,1,0,0, 0,0};
    vecs[22] = '{0,0,1, 0,1,0,0, 0,0};
    for (int i = 0; i < 23; i++) begin
      rst = vecs[i].rst; v = vecs[i].v; d = vecs[i].d;
      step();
      chk($sformatf("v%0d_isRun", i), run, vecs[i].run);
      chk($sformatf("v%0d_ready", i), rdy, vecs[i].rdy);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_dpulse", i), dp, vecs[i].dp);
      chk($sformatf("v%0d_pending", i), pend, vecs[i].pend);
      chk($sformatf("v%0d_count", i), cnt, vecs[i].cnt);
      chk($sformatf("v%0d_timeout", i), to, 0);
    end
    do_reset();
    since = 100; last = -1; pulses = 0; peak = 0; bad = 0; dps = 0;
    for (int t = 0; t < 60; t++) begin
      v = t < 5;
      since = since < 100 ? since + 1 : since;
      d = since == 3;
      step();
      if (int'(pend) > peak) peak = int'(pend);
      if (dp) dps++;
      if (run) begin
        if (last >= 0 && t - last != 6) bad++;
        last = t; pulses++; since = 0;
      end
    end
    d = 1'b0;
    chk("burst_peak_pending", peak, 4);
    chk("burst_isRun_pulses", pulses, 5);
    chk("burst_bad_spacing", bad, 0);
    chk("burst_done_pulses", dps, 5);
    chk("burst_count", cnt, 5);
    chk("burst_pending_end", pend, 0);
    chk("burst_busy_end", busy, 0);
    do_reset();
    v = 1'b1;
    for (int t = 0; t < 20; t++) step();
    chk("fill_pending", pend, 15);
    chk("fill_ready", rdy, 0);
    chk("fill_busy", busy, 1);
    chk("fill_isRun", run, 0);
    d = 1'b1;
    step();
    d = 1'b0;
    chk("fill_done_pulse", dp, 1);
    chk("fill_count", cnt, 1);
    chk("fill_pending_held", pend, 15);
    step();
    step();
    chk("fill_gap_pending", pend, 15);
    chk("fill_gap_ready", rdy, 0);
    step();
    chk("fill_issue_isRun", run, 1);
    chk("fill_issue_pending", pend, 14);
    chk("fill_issue_ready", rdy, 1);
    step();
    chk("fill_refill_pending", pend, 15);
    chk("fill_refill_ready", rdy, 0);
    chk("fill_refill_isRun", run, 0);
    do_reset();
    v = 1'b1;
    step();
    step();
    v = 1'b0;
    chk("hang_issue_isRun", run, 1);
    chk("hang_issue_pending", pend, 1);
    dps = 0;
`ifdef FSM_SEQ_TIMEOUT_EN
    n = 0;
    while (!to && n < 200) begin
      step();
      n++;
      if (dp) dps++;
    end
    chk("tmo_latency", n, 65);
    chk("tmo_count", cnt, 0);
    chk("tmo_done_pulses", dps, 0);
    runs = 0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (run) runs++;
    end
    chk("tmo_next_issued", runs, 1);
    chk("tmo_sticky", to, 1);
    chk("tmo_pending_end", pend, 0);
`else
    tos = 0; runs = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      if (to) tos++;
      if (run) runs++;
      if (dp) dps++;
    end
    chk("hang_timeout_seen", tos, 0);
    chk("hang_isRun_pulses", runs, 0);
    chk("hang_done_pulses", dps, 0);
    chk("hang_busy", busy, 1);
    chk("hang_count", cnt, 0);
    chk("hang_pending", pend, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
